alu_uart_iface: RTL and testbench
=================================

ALU_UART_IFACE -- requirements
Module: alu_uart_iface

Interface
- REQ-001 Parameter N, default 8: ALU operand/result width, legal range 1..8.
- REQ-002 Parameter NSel, default 6: ALU opcode width, legal range 1..8.
- REQ-003 Parameter TIMEOUT, default 16'd50000: idle clock cycles allowed between bytes of one frame.
- REQ-004 Clock and reset (already decided): one clock, i_clock; reset i_reset is asynchronous and active-low.
- REQ-005 Ports:
  - i_clock  in  1  system clock, all state on rising edge.
  - i_reset  in  1  asynchronous active-low reset.
  - i_rx_data  in  8  received UART byte.
  - i_rx_done  in  1  one-cycle pulse, i_rx_data valid.
  - i_tx_done  in  1  one-cycle pulse, UART transmitter finished a byte.
  - i_alu_Result  in  N  registered ALU result.
  - i_overflow_Flag  in  1  ALU overflow flag.
  - i_zero_Flag  in  1  ALU zero flag.
  - o_alu_A  out  N  operand A to ALU.
  - o_alu_B  out  N  operand B to ALU.
  - o_alu_Op  out  NSel  opcode to ALU.
  - o_tx_data  out  8  byte to transmit.
  - o_tx_start  out  1  one-cycle transmit request.
  - o_busy  out  1  high in EXEC/TX states.
  - o_frame_err  out  1  one-cycle pulse on inter-byte timeout.
  - o_rx_drop  out  1  one-cycle pulse when a byte is discarded.

Function
- REQ-006 FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, TX_RES, WAIT_RES, TX_FLG, WAIT_FLG.
- REQ-007 WAIT_A: on i_rx_done, o_alu_A <= i_rx_data[N-1:0], go to WAIT_B.
- REQ-008 WAIT_B: on i_rx_done, o_alu_B <= i_rx_data[N-1:0], go to WAIT_OP.
- REQ-009 WAIT_OP: on i_rx_done, o_alu_Op <= i_rx_data[NSel-1:0], go to EXEC; upper byte bits are ignored.
- REQ-010 EXEC lasts exactly 2 cycles, counted by an internal counter, to cover the ALU's one-cycle registered latency; on its last edge the block captures i_alu_Result (zero-extended to 8 bits) into o_tx_data and goes to TX_RES.
- REQ-011 Ordering: op byte sampled at edge t -> o_tx_start high for the cycle after edge t+2.
- REQ-012 TX_RES: o_tx_start high for exactly one cycle, then WAIT_RES.
- REQ-013 WAIT_RES: on i_tx_done, o_tx_data <= {6'b0, i_overflow_Flag, i_zero_Flag}, go to TX_FLG.
- REQ-014 TX_FLG: o_tx_start high for one cycle, then WAIT_FLG; on i_tx_done go to WAIT_A.
- REQ-015 Hold: o_alu_A, o_alu_B, o_alu_Op keep their value until overwritten by the next frame.
- REQ-016 o_tx_data is held stable from capture until the next capture.
- REQ-017 Timeout counter: cleared on every i_rx_done and on entry to WAIT_A; counts only in WAIT_B and WAIT_OP.
- REQ-018 When the count reaches TIMEOUT: pulse o_frame_err for one cycle, go to WAIT_A; o_alu_* outputs unchanged.
- REQ-019 Timeout saturates; no wrap-around.
- REQ-020 i_rx_done in EXEC, TX_RES, WAIT_RES, TX_FLG or WAIT_FLG: byte discarded, o_rx_drop pulses one cycle, state unaffected.
- REQ-021 i_tx_done outside WAIT_RES/WAIT_FLG is ignored.
- REQ-022 If i_rx_done and the timeout expiry coincide in one cycle, the byte wins: it is accepted and the counter is cleared.

Reset
- REQ-023 On i_reset low, immediately and independent of clock: state WAIT_A; counters 0; o_alu_A, o_alu_B, o_alu_Op, o_tx_data = 0; o_tx_start, o_busy, o_frame_err, o_rx_drop = 0.
- REQ-024 Reset asserted mid-frame or mid-transmit aborts the frame; no o_tx_start issues after release until a new full frame arrives.
- REQ-025 Reset release is synchronized to i_clock by the integrating top level.

Verification
- REQ-026 Bytes 0x05, 0x03, 0x20 (ADD), ALU model attached -> o_tx_start with o_tx_data=0x08 two cycles after the op byte; after i_tx_done, flag byte 0x00 transmitted.
- REQ-027 Bytes 0x7F, 0x01, 0x20 -> result 0x80; flag byte carries the ALU overflow flag in bit 1.
- REQ-028 Bytes 0x12 only, then idle TIMEOUT cycles -> one o_frame_err pulse, state WAIT_A; next bytes 0x01, 0x01, 0x24 -> result 0x01.
- REQ-029 Extra i_rx_done while in WAIT_RES -> o_rx_drop pulse; result/flag sequence unchanged.
- REQ-030 i_reset low while in WAIT_OP with A=0xAA -> all outputs 0 immediately; no o_tx_start until a new 3-byte frame arrives.
- REQ-031 Byte arrival on the exact TIMEOUT cycle -> accepted, no o_frame_err.

Source files
------------

// File: rtl/alu_uart_iface.sv
`default_nettype none
// ============================================================================
// alu_uart_iface : collects A, B and opcode bytes from a UART receiver, drives
// an external registered ALU, then sends back the result byte and a flag byte.
// Revision 1.0
// ============================================================================
module alu_uart_iface #(
  parameter int          N       = 8,
  parameter int          NSel    = 6,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_done,
  input  logic            i_tx_done,
  input  logic [N-1:0]    i_alu_Result,
  input  logic            i_overflow_Flag,
  input  logic            i_zero_Flag,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy,
  output logic            o_frame_err,
  output logic            o_rx_drop
);

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    TX_RES   = 3'd4,
    WAIT_RES = 3'd5,
    TX_FLG   = 3'd6,
    WAIT_FLG = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_exec_cnt;
  logic [15:0]     r_tmo_cnt;
  logic [N-1:0]    r_alu_a;
  logic [N-1:0]    r_alu_b;
  logic [NSel-1:0] r_alu_op;
  logic [7:0]      r_tx_data;
  logic            r_frame_err;
  logic            r_rx_drop;
  logic            w_collect;
  logic            w_tmo_hit;
  logic            w_busy;
  logic            w_tx_start;
  logic [7:0]      w_res_ext;
  logic            w_unused;

  // Only WAIT_B and WAIT_OP are mid-frame; the timeout watches those alone.
  assign w_collect = (r_state == WAIT_B) || (r_state == WAIT_OP);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_tmo_hit = w_collect && (r_tmo_cnt == TIMEOUT) && !i_rx_done;
  assign w_unused  = ^i_rx_data;

  always_comb begin
    w_res_ext        = '0;
    w_res_ext[N-1:0] = i_alu_Result;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b1;
    w_tx_start = 1'b0;
    case (r_state)
      WAIT_A: begin
        w_busy = 1'b0;
        if (i_rx_done) w_next = WAIT_B;
      end
      WAIT_B: begin
        w_busy = 1'b0;
        if (i_rx_done)      w_next = WAIT_OP;
        else if (w_tmo_hit) w_next = WAIT_A;
      end
      WAIT_OP: begin
        w_busy = 1'b0;
        if (i_rx_done)      w_next = EXEC;
        else if (w_tmo_hit) w_next = WAIT_A;
      end
      EXEC: begin
        if (r_exec_cnt) w_next = TX_RES;
      end
      TX_RES: begin
        w_tx_start = 1'b1;
        w_next     = WAIT_RES;
      end
      WAIT_RES: begin
        if (i_tx_done) w_next = TX_FLG;
      end
      TX_FLG: begin
        w_tx_start = 1'b1;
        w_next     = WAIT_FLG;
      end
      WAIT_FLG: begin
        if (i_tx_done) w_next = WAIT_A;
      end
      default: w_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_exec_cnt <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_exec_cnt <= (r_state == EXEC) ? ~r_exec_cnt : 1'b0;
      if (i_rx_done || !w_collect || w_tmo_hit) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt != TIMEOUT) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_tx_data   <= '0;
      r_frame_err <= 1'b0;
      r_rx_drop   <= 1'b0;
    end else begin
      r_frame_err <= w_tmo_hit;
      r_rx_drop   <= i_rx_done && w_busy;
      if (i_rx_done && (r_state == WAIT_A))  r_alu_a  <= i_rx_data[N-1:0];
      if (i_rx_done && (r_state == WAIT_B))  r_alu_b  <= i_rx_data[N-1:0];
      if (i_rx_done && (r_state == WAIT_OP)) r_alu_op <= i_rx_data[NSel-1:0];
      if ((r_state == EXEC) && r_exec_cnt) begin
        r_tx_data <= w_res_ext;
      end else if ((r_state == WAIT_RES) && i_tx_done) begin
        r_tx_data <= {6'b000000, i_overflow_Flag, i_zero_Flag};
      end
    end
  end

  assign o_alu_A     = r_alu_a;
  assign o_alu_B     = r_alu_b;
  assign o_alu_Op    = r_alu_op;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = w_tx_start;
  assign o_busy      = w_busy;
  assign o_frame_err = r_frame_err;
  assign o_rx_drop   = r_rx_drop;

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_iface.sv
`default_nettype none
// Bench for alu_uart_iface: an attached ALU model, directed and random frames
// checked against a byte-level reference of the returned result/flag bytes.
module tb_alu_uart_iface;

  localparam int N    = 8;
  localparam int NSEL = 6;
  localparam int TMO  = 40;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_done = 1'b0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    alu_res;
  logic            alu_ovf;
  logic            alu_zero;
  logic [N-1:0]    o_alu_A;
  logic [N-1:0]    o_alu_B;
  logic [NSEL-1:0] o_alu_Op;
  logic [7:0]      o_tx_data;
  logic            o_tx_start;
  logic            o_busy;
  logic            o_frame_err;
  logic            o_rx_drop;

  int nchk = 0;
  int nerr = 0;
  int n_start = 0;
  int n_ferr  = 0;
  int n_drop  = 0;

  alu_uart_iface #(.N(N), .NSel(NSEL), .TIMEOUT(16'(TMO))) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_done      (rx_done),
    .i_tx_done      (tx_done),
    .i_alu_Result   (alu_res),
    .i_overflow_Flag(alu_ovf),
    .i_zero_Flag    (alu_zero),
    .o_alu_A        (o_alu_A),
    .o_alu_B        (o_alu_B),
    .o_alu_Op       (o_alu_Op),
    .o_tx_data      (o_tx_data),
    .o_tx_start     (o_tx_start),
    .o_busy         (o_busy),
    .o_frame_err    (o_frame_err),
    .o_rx_drop      (o_rx_drop)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {result[7:0], overflow, zero}.
  function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (op)
      6'h20: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      6'h22: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b[2:0];
      6'h03: r = $signed(a) >>> b[2:0];
      default: r = 8'h00;
    endcase
    return {r, v, (r == 8'h00)};
  endfunction

  // External ALU with one cycle of registered latency.
  always @(posedge clk) {alu_res, alu_ovf, alu_zero} <= alu_ref(o_alu_A, o_alu_B, o_alu_Op);

  always @(negedge clk) begin
    if (o_tx_start === 1'b1)  n_start <= n_start + 1;
    if (o_frame_err === 1'b1) n_ferr  <= n_ferr + 1;
    if (o_rx_drop === 1'b1)   n_drop  <= n_drop + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int gap1, input int gap2, input int txlat, input string tag);
    logic [9:0] exp;
    logic [7:0] flg;
    exp = alu_ref(a, b, op[5:0]);
    flg = {6'b000000, exp[1:0]};
    rx_byte(a); idle(gap1); rx_byte(b); idle(gap2); rx_byte(op);
    nchk++;
    if ({o_busy, o_tx_start, o_alu_A, o_alu_B, o_alu_Op} !== {1'b1, 1'b0, a, b, op[5:0]}) begin
      nerr++;
      $display("FAIL %s operands: got busy=%b start=%b A=%h B=%h Op=%h want busy=1 start=0 A=%h B=%h Op=%h",
               tag, o_busy, o_tx_start, o_alu_A, o_alu_B, o_alu_Op, a, b, op[5:0]);
    end
    idle(1);
    nchk++;
    if (o_tx_start !== 1'b0) begin
      nerr++; $display("FAIL %s early_start: got start=%b want 0", tag, o_tx_start);
    end
    idle(1);
    nchk++;
    if ({o_tx_start, o_tx_data} !== {1'b1, exp[9:2]}) begin
      nerr++;
      $display("FAIL %s result: got start=%b data=%h want start=1 data=%h", tag, o_tx_start, o_tx_data, exp[9:2]);
    end
    idle(1);
    nchk++;
    if ({o_tx_start, o_busy, o_tx_data} !== {2'b01, exp[9:2]}) begin
      nerr++;
      $display("FAIL %s result_hold: got start=%b busy=%b data=%h want start=0 busy=1 data=%h",
               tag, o_tx_start, o_busy, o_tx_data, exp[9:2]);
    end
    idle(txlat);
    tx_done = 1'b1; idle(1); tx_done = 1'b0;
    nchk++;
    if ({o_tx_start, o_tx_data} !== {1'b1, flg}) begin
      nerr++;
      $display("FAIL %s flags: got start=%b data=%h want start=1 data=%h", tag, o_tx_start, o_tx_data, flg);
    end
    idle(txlat + 1);
    tx_done = 1'b1; idle(1); tx_done = 1'b0;
    nchk++;
    if ({o_busy, o_tx_start} !== 2'b00) begin
      nerr++; $display("FAIL %s done: got busy=%b start=%b want 0 0", tag, o_busy, o_tx_start);
    end
  endtask

  task automatic test_reset();
    idle(3);
    nchk++;
    if ({o_alu_A, o_alu_B, o_alu_Op, o_tx_data} !== '0) begin
      nerr++; $display("FAIL reset_data: got A=%h B=%h Op=%h tx=%h want all 0", o_alu_A, o_alu_B, o_alu_Op, o_tx_data);
    end
    nchk++;
    if ({o_tx_start, o_busy, o_frame_err, o_rx_drop} !== 4'b0000) begin
      nerr++; $display("FAIL reset_ctrl: got %b want 0000", {o_tx_start, o_busy, o_frame_err, o_rx_drop});
    end
    rst_n = 1'b1;
    idle(3);
    nchk++;
    if ({o_busy, o_tx_start, o_tx_data} !== 10'd0) begin
      nerr++; $display("FAIL post_reset_idle: got busy=%b start=%b tx=%h want 0", o_busy, o_tx_start, o_tx_data);
    end
  endtask

  task automatic test_directed();
    do_frame(8'h05, 8'h03, 8'h20, 2, 3, 2, "add");
    do_frame(8'h7F, 8'h01, 8'h20, 1, 1, 0, "overflow");
    do_frame(8'h10, 8'h10, 8'hE2, 0, 4, 3, "sub_zero_opmask");
  endtask

  task automatic test_timeout();
    int         e0;
    logic [7:0] b_prev;
    e0     = n_ferr;
    b_prev = o_alu_B;
    rx_byte(8'h12);
    idle(TMO + 5);
    nchk++;
    if (n_ferr - e0 != 1) begin
      nerr++; $display("FAIL timeout_pulse: got %0d frame_err cycles want 1", n_ferr - e0);
    end
    nchk++;
    if ({o_alu_A, o_alu_B, o_busy} !== {8'h12, b_prev, 1'b0}) begin
      nerr++;
      $display("FAIL timeout_hold: got A=%h B=%h busy=%b want A=12 B=%h busy=0", o_alu_A, o_alu_B, o_busy, b_prev);
    end
    do_frame(8'h01, 8'h01, 8'h24, 1, 1, 1, "after_timeout");
  endtask

  task automatic test_timeout_boundary();
    int e0;
    e0 = n_ferr;
    do_frame(8'h0A, 8'h05, 8'h22, TMO, TMO, 1, "edge_accept");
    nchk++;
    if (n_ferr != e0) begin
      nerr++; $display("FAIL edge_no_err: got %0d frame_err cycles want 0", n_ferr - e0);
    end
    rx_byte(8'h33);
    idle(TMO + 1);
    do_frame(8'h44, 8'h02, 8'h20, 0, 0, 1, "one_past_edge");
    nchk++;
    if (n_ferr - e0 != 1) begin
      nerr++; $display("FAIL one_past_err: got %0d frame_err cycles want 1", n_ferr - e0);
    end
  endtask

  task automatic test_drop();
    int d0;
    d0 = n_drop;
    rx_byte(8'h05); rx_byte(8'h03); rx_byte(8'h20);
    rx_byte(8'h99);
    nchk++;
    if (o_tx_start !== 1'b0) begin
      nerr++; $display("FAIL drop_exec_start: got %b want 0", o_tx_start);
    end
    idle(1);
    nchk++;
    if ({o_tx_start, o_tx_data} !== {1'b1, 8'h08}) begin
      nerr++; $display("FAIL drop_result: got start=%b data=%h want 1 08", o_tx_start, o_tx_data);
    end
    tx_done = 1'b1; idle(1); tx_done = 1'b0;
    nchk++;
    if ({o_tx_start, o_tx_data} !== {1'b0, 8'h08}) begin
      nerr++; $display("FAIL txdone_in_txres: got start=%b data=%h want 0 08", o_tx_start, o_tx_data);
    end
    rx_byte(8'h77);
    idle(2);
    nchk++;
    if ({n_drop - d0, o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_busy} !==
        {32'd2, 8'h05, 8'h03, 6'h20, 8'h08, 1'b1}) begin
      nerr++;
      $display("FAIL drop_state: got drops=%0d A=%h B=%h Op=%h tx=%h busy=%b want 2 05 03 20 08 1",
               n_drop - d0, o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_busy);
    end
    tx_done = 1'b1; idle(1);
    nchk++;
    if ({o_tx_start, o_tx_data} !== {1'b1, 8'h00}) begin
      nerr++; $display("FAIL drop_flags: got start=%b data=%h want 1 00", o_tx_start, o_tx_data);
    end
    idle(1); tx_done = 1'b0;
    nchk++;
    if ({o_busy, o_tx_start} !== 2'b10) begin
      nerr++; $display("FAIL txdone_in_txflg: got busy=%b start=%b want 1 0", o_busy, o_tx_start);
    end
    idle(1);
    tx_done = 1'b1; idle(1); tx_done = 1'b0;
    nchk++;
    if (o_busy !== 1'b0) begin
      nerr++; $display("FAIL drop_end: got busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_tx_done_ignored();
    int s0;
    s0 = n_start;
    tx_done = 1'b1; idle(1); tx_done = 1'b0;
    rx_byte(8'h10);
    tx_done = 1'b1; idle(1); tx_done = 1'b0;
    idle(2);
    nchk++;
    if ((n_start != s0) || (o_busy !== 1'b0)) begin
      nerr++; $display("FAIL stray_txdone: got starts=%0d busy=%b want 0 0", n_start - s0, o_busy);
    end
    idle(TMO + 5);
  endtask

  task automatic test_reset_midframe();
    int s0;
    rx_byte(8'hAA); rx_byte(8'h55);
    nchk++;
    if (o_alu_A !== 8'hAA) begin
      nerr++; $display("FAIL pre_reset_A: got %h want aa", o_alu_A);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_tx_start, o_busy, o_frame_err, o_rx_drop} !== '0) begin
      nerr++;
      $display("FAIL async_reset: got A=%h B=%h Op=%h tx=%h ctrl=%b want all 0",
               o_alu_A, o_alu_B, o_alu_Op, o_tx_data, {o_tx_start, o_busy, o_frame_err, o_rx_drop});
    end
    idle(2);
    rst_n = 1'b1;
    s0 = n_start;
    rx_byte(8'h20);
    idle(8);
    nchk++;
    if ((n_start != s0) || (o_busy !== 1'b0)) begin
      nerr++; $display("FAIL reset_abort: got starts=%0d busy=%b want 0 0", n_start - s0, o_busy);
    end
    idle(TMO + 5);
    do_frame(8'h0C, 8'h04, 8'h22, 1, 1, 2, "post_reset");
  endtask

  task automatic test_back_to_back();
    do_frame(8'h81, 8'h80, 8'h20, 0, 0, 0, "b2b_0");
    do_frame(8'hF0, 8'h0F, 8'h27, 0, 0, 0, "b2b_1");
    do_frame(8'h80, 8'h01, 8'h22, 0, 0, 0, "b2b_2");
  endtask

  task automatic test_random();
    logic [5:0] ops [0:7];
    logic [7:0] a, b, op;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    for (int i = 0; i < 20; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = (8'($urandom) & 8'hC0) | {2'b00, ops[$urandom_range(0, 7)]};
      do_frame(a, b, op, int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)),
               int'($urandom_range(0, 5)), "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_timeout_boundary();
    test_drop();
    test_tx_done_ignored();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
